// File: rtl/irq_ctrl_pkg.sv
// Purpose: shared CPU definitions for the interrupt controller: register offsets, CTRL/CAUSE bit positions, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package irq_ctrl_pkg;

    // Register offsets, decoded from Addr[3:2]
    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_CAUSE = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;   // 0 = level, 1 = edge

    // Width of a latched source id
    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_EOI_WAIT = 2'd2
    } irq_state_t;

    // CAUSE read value: valid flag in bit31, source id in bits[2:0]
    function automatic logic [31:0] cause_word(input logic valid, input logic [ID_W-1:0] id);
        return valid ? {1'b1, 28'd0, id} : 32'd0;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Purpose: fixed-priority encoder, lowest set index wins (bit 0 highest priority).
// Latency: combinational.
// Backpressure: none.
//
// Ports: req [NSRC-1:0] in; vld (any request) and idx [2:0] (winning index) out.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req,
    output logic            vld,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest requesting index is the last one written.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[ID_W-1:0];
            end
        end
        vld = |req;
    end

endmodule

// File: rtl/irq_ctrl.sv
// Purpose: memory-mapped interrupt controller, NSRC sources, level/edge modes, single outstanding request to the CPU.
// Latency: irq_in rise before edge k -> PEND after edge k -> IRQ after edge k+1; IRQ low >= 2 cycles after EOI.
// Backpressure: none; register writes and FSM updates always complete in the cycle they are presented.
//
// Ports: clk, reset (async active-low); Addr[31:2]/WE/Din register write, Dout combinational read
//        from Addr[3:2]; irq_in[NSRC-1:0] source requests; IRQ registered request to the CPU.
module irq_ctrl #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] irq_in,
    output logic            IRQ
);

    import irq_ctrl_pkg::*;

    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] prev_q;
    logic            en_q;
    logic            mode_q;
    irq_state_t      state_q;
    logic [ID_W-1:0] cur_id_q;
    logic            irq_q;

    logic [1:0]      sel;
    logic            wr_mask;
    logic            wr_pend;
    logic            wr_cause;
    logic            wr_ctrl;
    logic            eoi;
    logic [NSRC-1:0] src_edge;
    logic [NSRC-1:0] pend_vis;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] clr_w1c;
    logic [NSRC-1:0] clr_eoi;
    logic [NSRC-1:0] pend_nxt;
    logic            win_vld;
    logic [ID_W-1:0] win_idx;

    // Only Addr[3:2] is decoded; upper address and data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{Addr[31:4], Din};

    assign sel      = Addr[3:2];
    assign wr_mask  = WE && (sel == REG_MASK);
    assign wr_pend  = WE && (sel == REG_PEND);
    assign wr_cause = WE && (sel == REG_CAUSE);
    assign wr_ctrl  = WE && (sel == REG_CTRL);

    // A CAUSE write only means EOI while a request is outstanding.
    assign eoi = wr_cause && (state_q == ST_ACTIVE);

    assign src_edge = irq_in & ~prev_q;

    // In level mode PEND mirrors the registered input directly; pend_q only matters in edge mode.
    assign pend_vis = mode_q ? pend_q : prev_q;
    assign req      = pend_vis & mask_q;

    always_comb begin
        clr_w1c = wr_pend ? Din[NSRC-1:0] : '0;
        clr_eoi = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr_eoi[i] = eoi && (cur_id_q == i[ID_W-1:0]);
        end
    end

    // Edge mode: clear first, then OR in new edges so a coincident set wins.
    // Level mode: track irq_in so pend_q is already consistent if software switches to edge mode.
    assign pend_nxt = mode_q ? ((pend_q & ~(clr_w1c | clr_eoi)) | src_edge) : irq_in;

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .req (req),
        .vld (win_vld),
        .idx (win_idx)
    );

    // Software-visible registers and input history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            en_q   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            prev_q <= irq_in;
            pend_q <= pend_nxt;
            if (wr_mask) begin
                mask_q <= Din[NSRC-1:0];
            end
            if (wr_ctrl) begin
                en_q   <= Din[CTRL_EN_BIT];
                mode_q <= Din[CTRL_MODE_BIT];
            end
        end
    end

    // Request FSM; IRQ is registered alongside the state so it is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cur_id_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_q && win_vld) begin
                        cur_id_q <= win_idx;
                        irq_q    <= 1'b1;
                        state_q  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // cur_id and IRQ are frozen here; only EOI releases them.
                    if (eoi) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_EOI_WAIT;
                    end
                end
                ST_EOI_WAIT: begin
                    // One dead cycle guarantees a visible low gap before the next request.
                    state_q <= ST_IDLE;
                end
                default: begin
                    irq_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign IRQ = irq_q;

    always_comb begin
        Dout = 32'd0;
        case (sel)
            REG_MASK:  Dout = {{(32-NSRC){1'b0}}, mask_q};
            REG_PEND:  Dout = {{(32-NSRC){1'b0}}, pend_vis};
            REG_CAUSE: Dout = cause_word(state_q == ST_ACTIVE, cur_id_q);
            REG_CTRL:  Dout = {30'd0, mode_q, en_q};
            default:   Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Purpose: directed self-checking bench for irq_ctrl; expectations queued at stimulus, popped at observation.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_ctrl;

    localparam int NSRC = 4;
    localparam logic [1:0] A_MASK  = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_CAUSE = 2'd2;
    localparam logic [1:0] A_CTRL  = 2'd3;

    logic            clk;
    logic            reset;
    logic [31:2]     Addr;
    logic            WE;
    logic [31:0]     Din;
    logic [31:0]     Dout;
    logic [NSRC-1:0] irq_in;
    logic            IRQ;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    irq_ctrl #(
        .NSRC (NSRC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .irq_in (irq_in),
        .IRQ    (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic compare(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_underflow observed=0x%08h expected=<none>", obs);
            return;
        end
        tag = tag_q.pop_front();
        e   = exp_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic chk_reg(input logic [1:0] a);
        Addr = {28'd0, a};
        WE   = 1'b0;
        #1;
        compare(Dout);
    endtask

    task automatic chk_irq();
        compare({31'd0, IRQ});
    endtask

    task automatic pulse(input logic [NSRC-1:0] v);
        irq_in = v;
        step();
        irq_in = '0;
    endtask

    initial begin
        reset  = 1'b0;
        WE     = 1'b0;
        Addr   = '0;
        Din    = 32'd0;
        irq_in = '0;

        // Reset state
        #12;
        push_exp("rst_irq", 32'd0);    chk_irq();
        push_exp("rst_mask", 32'd0);   chk_reg(A_MASK);
        push_exp("rst_pend", 32'd0);   chk_reg(A_PEND);
        push_exp("rst_cause", 32'd0);  chk_reg(A_CAUSE);
        push_exp("rst_ctrl", 32'd0);   chk_reg(A_CTRL);
        #3;
        reset = 1'b1;
        step();

        // Unimplemented bits, CAUSE write outside ACTIVE
        wr(A_MASK, 32'hFFFF_FFFF);
        push_exp("mask_unimpl", 32'h0000_000F);  chk_reg(A_MASK);
        wr(A_CTRL, 32'hFFFF_FFFC);
        push_exp("ctrl_unimpl", 32'd0);          chk_reg(A_CTRL);
        wr(A_CAUSE, 32'hFFFF_FFFF);
        push_exp("cause_idle", 32'd0);           chk_reg(A_CAUSE);
        push_exp("idle_irq", 32'd0);             chk_irq();

        // Edge mode single pulse on source 1
        wr(A_MASK, 32'h3);
        wr(A_CTRL, 32'h3);
        push_exp("ctrl_rb", 32'h3);              chk_reg(A_CTRL);
        push_exp("e1_pend", 32'h2);
        push_exp("e1_irq_k", 32'd0);
        pulse(4'b0010);
        chk_reg(A_PEND);
        chk_irq();
        push_exp("e1_irq", 32'd1);
        push_exp("e1_cause", 32'h8000_0001);
        step();
        chk_irq();
        chk_reg(A_CAUSE);
        push_exp("e1_eoi_irq", 32'd0);
        push_exp("e1_eoi_pend", 32'd0);
        push_exp("e1_eoi_cause", 32'd0);
        wr(A_CAUSE, 32'd0);
        chk_irq();
        chk_reg(A_PEND);
        chk_reg(A_CAUSE);
        step();

        // Priority: sources 0 and 2 together
        wr(A_MASK, 32'hF);
        irq_in = 4'b0101;
        push_exp("pr_pend", 32'h5);
        step();
        chk_reg(A_PEND);
        push_exp("pr_irq0", 32'd1);
        push_exp("pr_cause0", 32'h8000_0000);
        step();
        chk_irq();
        chk_reg(A_CAUSE);
        push_exp("pr_gap1", 32'd0);
        push_exp("pr_pend_after", 32'h4);
        wr(A_CAUSE, 32'd0);
        chk_irq();
        chk_reg(A_PEND);
        push_exp("pr_gap2", 32'd0);
        step();
        chk_irq();
        push_exp("pr_irq2", 32'd1);
        push_exp("pr_cause2", 32'h8000_0002);
        step();
        chk_irq();
        chk_reg(A_CAUSE);
        irq_in = '0;
        push_exp("pr_final_pend", 32'd0);
        wr(A_CAUSE, 32'd0);
        chk_reg(A_PEND);
        step();

        // Level mode, source 3 held
        wr(A_CTRL, 32'h1);
        wr(A_MASK, 32'h8);
        irq_in = 4'b1000;
        push_exp("lv_pend", 32'h8);
        push_exp("lv_irq_k", 32'd0);
        step();
        chk_reg(A_PEND);
        chk_irq();
        push_exp("lv_irq", 32'd1);
        push_exp("lv_cause", 32'h8000_0003);
        step();
        chk_irq();
        chk_reg(A_CAUSE);
        push_exp("lv_eoi_irq", 32'd0);
        push_exp("lv_eoi_pend", 32'h8);
        wr(A_CAUSE, 32'd0);
        chk_irq();
        chk_reg(A_PEND);
        push_exp("lv_gap", 32'd0);
        step();
        chk_irq();
        push_exp("lv_reassert", 32'd1);
        step();
        chk_irq();
        irq_in = '0;
        push_exp("lv_hold_irq", 32'd1);
        push_exp("lv_drop_pend", 32'd0);
        step();
        chk_irq();
        chk_reg(A_PEND);
        wr(A_CAUSE, 32'd0);
        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("lv_quiet%0d", i), 32'd0);
            chk_irq();
            step();
        end

        // Edge mode: new edge on cur_id coincident with EOI
        wr(A_CTRL, 32'h3);
        pulse(4'b1000);
        push_exp("co_irq", 32'd1);
        step();
        chk_irq();
        irq_in = 4'b1000;
        push_exp("co_pend", 32'h8);
        push_exp("co_irq_low", 32'd0);
        wr(A_CAUSE, 32'd0);
        irq_in = '0;
        chk_reg(A_PEND);
        chk_irq();
        step();
        push_exp("co_reassert", 32'd1);
        push_exp("co_cause", 32'h8000_0003);
        step();
        chk_irq();
        chk_reg(A_CAUSE);
        push_exp("co_pend_clr", 32'd0);
        wr(A_CAUSE, 32'd0);
        chk_reg(A_PEND);
        step();

        // MASK and EN cleared while ACTIVE
        pulse(4'b1000);
        step();
        push_exp("ma_mask0_irq", 32'd1);
        wr(A_MASK, 32'd0);
        chk_irq();
        push_exp("ma_en0_irq", 32'd1);
        push_exp("ma_en0_cause", 32'h8000_0003);
        wr(A_CTRL, 32'h2);
        chk_irq();
        chk_reg(A_CAUSE);
        pulse(4'b0001);
        push_exp("ma_eoi_irq", 32'd0);
        push_exp("ma_eoi_pend", 32'h1);
        wr(A_CAUSE, 32'd0);
        chk_irq();
        chk_reg(A_PEND);
        for (int i = 0; i < 3; i++) begin
            step();
            push_exp($sformatf("ma_quiet%0d", i), 32'd0);
            chk_irq();
        end
        push_exp("w1c_pend", 32'd0);
        wr(A_PEND, 32'h1);
        chk_reg(A_PEND);
        pulse(4'b0001);
        wr(A_MASK, 32'h1);
        step();
        push_exp("en_off_irq", 32'd0);
        chk_irq();
        push_exp("en_set_irq", 32'd0);
        wr(A_CTRL, 32'h3);
        chk_irq();
        push_exp("en_on_irq", 32'd1);
        push_exp("en_on_cause", 32'h8000_0000);
        step();
        chk_irq();
        chk_reg(A_CAUSE);

        // Asynchronous reset mid-ACTIVE, away from the clock edge
        #3;
        reset = 1'b0;
        #1;
        push_exp("ar_irq", 32'd0);     chk_irq();
        push_exp("ar_mask", 32'd0);    chk_reg(A_MASK);
        push_exp("ar_pend", 32'd0);    chk_reg(A_PEND);
        push_exp("ar_cause", 32'd0);   chk_reg(A_CAUSE);
        push_exp("ar_ctrl", 32'd0);    chk_reg(A_CTRL);
        @(negedge clk);
        reset = 1'b1;
        step();
        push_exp("post_rst_irq", 32'd0);
        chk_irq();

        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
